// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and consumes results; slave is the adder.
`timescale 1ns/1ps
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, in1, in2, sub, out_ready,
        input  in_ready, out_valid, sum,
        input  carry_out, overflow, zero, busy
    );

    modport slave (
        input  in_valid, in1, in2, sub, out_ready,
        output in_ready, out_valid, sum,
        output carry_out, overflow, zero, busy
    );
endinterface

// File: rtl/pipelined_adder.sv
// Segmented ripple adder/subtractor, one SEG-bit slice per stage,
// valid/ready handshake with whole-pipeline stall on back-pressure.
`timescale 1ns/1ps
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad
        $error("pipelined_adder: STAGES must divide WIDTH");
    end

    logic              adv;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] cy_d;
    logic [STAGES-1:0] c_in;
    logic [WIDTH-1:0]  ps_q [STAGES];
    logic [WIDTH-1:0]  ps_d [STAGES];
    logic [WIDTH-1:0]  p_in [STAGES];
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic              ov_q;
    logic              zr_q;
    logic              ov_d;
    logic              zr_d;

    assign adv = !vld[STAGES-1] | bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG:0]     seg;
        logic [WIDTH-1:0] nps;

        if (k == 0) begin : g_head
            assign a_in[k] = bus.in1;
            assign b_in[k] = bus.sub ? ~bus.in2 : bus.in2;
            assign p_in[k] = '0;
            assign c_in[k] = bus.sub;
        end else begin : g_tail
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign p_in[k] = ps_q[k-1];
            assign c_in[k] = cy_q[k-1];
        end

        assign seg = {1'b0, a_in[k][k*SEG +: SEG]}
                   + {1'b0, b_in[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_in[k]};

        always_comb begin
            nps = p_in[k];
            nps[k*SEG +: SEG] = seg[SEG-1:0];
        end

        assign ps_d[k] = nps;
        assign cy_d[k] = seg[SEG];
    end

    // Flags use the full operands carried down to the last slice.
    assign ov_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
                & (ps_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
    assign zr_d = (ps_d[STAGES-1] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            cy_q <= '0;
            ov_q <= 1'b0;
            zr_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                ps_q[k] <= '0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
            end
        end else if (adv) begin
            vld[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld[k] <= vld[k-1];
            end
            cy_q <= cy_d;
            ov_q <= ov_d;
            zr_q <= zr_d;
            for (int k = 0; k < STAGES; k++) begin
                ps_q[k] <= ps_d[k];
                a_q[k]  <= a_in[k];
                b_q[k]  <= b_in[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum       = ps_q[STAGES-1];
    assign bus.carry_out = cy_q[STAGES-1];
    assign bus.overflow  = ov_q;
    assign bus.zero      = zr_q;
    assign bus.busy      = |vld;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder in four shapes: 32/2, 32/1, 32/4, 8/8.
// Arithmetic reference model plus queue scoreboard on random streams.
`timescale 1ns/1ps
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        sub;
    logic        out_ready;
    logic [31:0] in1;
    logic [31:0] in2;

    int n_cmp = 0;
    int n_bad = 0;

    int wd [4] = '{32, 32, 32, 8};
    int st [4] = '{2, 1, 4, 8};

    logic [3:0]  o_vld, o_rdy, o_cy, o_ov, o_zr, o_busy;
    logic [31:0] o_sum [4];

    pipelined_adder_if #(.WIDTH(32)) b0 ();
    pipelined_adder_if #(.WIDTH(32)) b1 ();
    pipelined_adder_if #(.WIDTH(32)) b2 ();
    pipelined_adder_if #(.WIDTH(8))  b3 ();

    pipelined_adder #(.WIDTH(32), .STAGES(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    pipelined_adder #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pipelined_adder #(.WIDTH(32), .STAGES(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    pipelined_adder #(.WIDTH(8),  .STAGES(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    assign b0.in_valid = in_valid;
    assign b0.in1 = in1;
    assign b0.in2 = in2;
    assign b0.sub = sub;
    assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid;
    assign b1.in1 = in1;
    assign b1.in2 = in2;
    assign b1.sub = sub;
    assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid;
    assign b2.in1 = in1;
    assign b2.in2 = in2;
    assign b2.sub = sub;
    assign b2.out_ready = out_ready;
    assign b3.in_valid = in_valid;
    assign b3.in1 = in1[7:0];
    assign b3.in2 = in2[7:0];
    assign b3.sub = sub;
    assign b3.out_ready = out_ready;

    assign o_vld  = {b3.out_valid, b2.out_valid, b1.out_valid, b0.out_valid};
    assign o_rdy  = {b3.in_ready, b2.in_ready, b1.in_ready, b0.in_ready};
    assign o_cy   = {b3.carry_out, b2.carry_out, b1.carry_out, b0.carry_out};
    assign o_ov   = {b3.overflow, b2.overflow, b1.overflow, b0.overflow};
    assign o_zr   = {b3.zero, b2.zero, b1.zero, b0.zero};
    assign o_busy = {b3.busy, b2.busy, b1.busy, b0.busy};
    assign o_sum[0] = b0.sum;
    assign o_sum[1] = b1.sum;
    assign o_sum[2] = b2.sum;
    assign o_sum[3] = {24'd0, b3.sum};

    always #5 clk = ~clk;

    // Returns {carry, overflow, zero, sum} from plain integer arithmetic.
    function automatic logic [34:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic s);
        longint m, aa, bb, r, sa, sb, sr;
        logic   cy, ov;
        logic [63:0] rv;
        m  = longint'(1) << w;
        aa = {32'd0, a};
        bb = {32'd0, b};
        aa = aa & (m - 1);
        bb = bb & (m - 1);
        r  = s ? aa - bb : aa + bb;
        r  = r & (m - 1);
        rv = r;
        cy = s ? (aa >= bb) : (aa + bb >= m);
        sa = (aa >= m / 2) ? aa - m : aa;
        sb = (bb >= m / 2) ? bb - m : bb;
        sr = s ? sa - sb : sa + sb;
        ov = (sr >= m / 2) || (sr < -(m / 2));
        return {cy, ov, (r == 0), rv[31:0]};
    endfunction

    function automatic logic [31:0] mask_of(input int d);
        return (wd[d] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
        sub = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if ({o_vld[d], o_cy[d], o_ov[d], o_zr[d], o_busy[d], o_rdy[d]} !== 6'b000001
                || o_sum[d] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset d=%0d got vld/cy/ov/zr/busy/rdy=%b sum=%h want 000001 sum=0",
                         d, {o_vld[d], o_cy[d], o_ov[d], o_zr[d], o_busy[d], o_rdy[d]}, o_sum[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (o_busy[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL first_accept d=%0d busy=%b want 1", d, o_busy[d]);
            end
        end
    endtask

    task automatic run_one(input int d, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        logic [34:0] exp;
        logic [34:0] got;
        @(negedge clk);
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        sub = s;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
        sub = ~s;
        for (int i = 1; i < st[d]; i++) begin
            n_cmp++;
            if (o_vld[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL early_valid d=%0d cycle=%0d out_valid=%b want 0", d, i, o_vld[d]);
            end
            @(negedge clk);
        end
        exp = ref_op(wd[d], a & mask_of(d), b & mask_of(d), s);
        got = {o_cy[d], o_ov[d], o_zr[d], o_sum[d]};
        n_cmp++;
        if (o_vld[d] !== 1'b1 || got !== exp) begin
            n_bad++;
            $display("FAIL vector d=%0d a=%h b=%h sub=%b got vld=%b cy/ov/zr/sum=%h want 1 %h",
                     d, a, b, s, o_vld[d], got, exp);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] m;
        for (int d = 0; d < 4; d++) begin
            do_reset();
            m = mask_of(d);
            run_one(d, 32'd5, 32'd7, 1'b0);
            run_one(d, m, 32'd1, 1'b0);
            run_one(d, m >> 1, 32'd1, 1'b0);
            run_one(d, 32'd3, 32'd5, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int got = 0;
        int stall_left = 0;
        bit seen = 0;
        do_reset();
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            @(negedge clk);
            in_valid = (idx < 3);
            in1 = idx + 1;
            in2 = idx + 1;
            sub = 1'b0;
            if (o_vld[0] && !seen) begin
                seen = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                n_cmp++;
                if (o_vld[0] !== 1'b1 || o_sum[0] !== 32'd2 || o_rdy[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_hold vld=%b sum=%0d in_ready=%b want 1 2 0",
                             o_vld[0], o_sum[0], o_rdy[0]);
                end
            end else if (o_vld[0] && out_ready) begin
                got++;
                n_cmp++;
                if (o_sum[0] !== 32'(2 * got)) begin
                    n_bad++;
                    $display("FAIL b2b_order result=%0d sum=%0d want %0d", got, o_sum[0], 2 * got);
                end
            end
            if (in_valid && o_rdy[0]) idx++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got !== 3) begin
            n_bad++;
            $display("FAIL b2b_count results=%0d want 3", got);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in1 = 32'd10;
        in2 = 32'd20;
        sub = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in1 = 32'd30;
        in2 = 32'd40;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        n_cmp++;
        if (o_busy[0] !== 1'b1 || o_vld[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL inflight busy=%b vld=%b want 1 1", o_busy[0], o_vld[0]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_busy[0] !== 1'b0 || o_vld[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset busy=%b vld=%b want 0 0", o_busy[0], o_vld[0]);
        end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o_vld[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL ghost_result cycle=%0d out_valid=%b want 0", i, o_vld[0]);
            end
        end
    endtask

    task automatic test_random(input int d);
        logic [34:0] q[$];
        logic [34:0] exp;
        logic [34:0] got;
        logic [31:0] m;
        logic [31:0] hold_s = '0;
        bit hold_v = 0;
        m = mask_of(d);
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc >= 400 && q.size() == 0) break;
            @(negedge clk);
            in_valid = (cyc < 400) && ($urandom_range(3) != 0);
            case ($urandom_range(3))
                0: in1 = m;
                1: in1 = m >> 1;
                default: in1 = $urandom;
            endcase
            in2 = ($urandom_range(4) == 0) ? 32'd1 : $urandom;
            sub = $urandom_range(1);
            out_ready = (cyc >= 400) || ($urandom_range(3) != 0);
            #1;
            if (hold_v) begin
                n_cmp++;
                if (o_vld[d] !== 1'b1 || o_sum[d] !== hold_s) begin
                    n_bad++;
                    $display("FAIL rnd_hold d=%0d vld=%b sum=%h want 1 %h", d, o_vld[d], o_sum[d], hold_s);
                end
            end
            n_cmp++;
            if (o_busy[d] !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL rnd_busy d=%0d busy=%b want %b", d, o_busy[d], q.size() != 0);
            end
            if (o_vld[d] && out_ready) begin
                n_cmp++;
                got = {o_cy[d], o_ov[d], o_zr[d], o_sum[d]};
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_spurious d=%0d got=%h want no result", d, got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL rnd_result d=%0d got=%h want %h", d, got, exp);
                    end
                end
            end
            hold_v = o_vld[d] && !out_ready;
            hold_s = o_sum[d];
            if (in_valid && o_rdy[d])
                q.push_back(ref_op(wd[d], in1 & m, in2 & m, sub));
        end
        in_valid = 1'b0;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL rnd_drain d=%0d pending=%0d want 0", d, q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sub = 1'b0;
        in1 = '0;
        in2 = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_midreset();
        for (int d = 0; d < 4; d++) test_random(d);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
- REQ-001: Parameter WIDTH, default 32, operand and result width in bits.
- REQ-002: Parameter STAGES, default 2, number of pipeline stages; each stage adds one segment of SEG = WIDTH/STAGES bits.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: in_valid  input  1  operands and mode are presented this cycle.
- REQ-006: in_ready  output  1  block accepts an operation this cycle.
- REQ-007: in1  input  WIDTH  first operand.
- REQ-008: in2  input  WIDTH  second operand.
- REQ-009: sub  input  1  0 = in1+in2, 1 = in1-in2.
- REQ-010: out_valid  output  1  result on sum/flags is valid.
- REQ-011: out_ready  input  1  consumer takes the result this cycle.
- REQ-012: sum  output  WIDTH  result modulo 2^WIDTH.
- REQ-013: carry_out  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- REQ-014: overflow  output  1  two's-complement signed overflow of the selected operation.
- REQ-015: zero  output  1  sum == 0.
- REQ-016: busy  output  1  at least one pipeline stage holds a valid operation.

Function
- REQ-017: Elaboration fails unless STAGES >= 1, STAGES <= WIDTH and WIDTH % STAGES == 0.
- REQ-018: Subtraction is computed as in1 + ~in2 + 1; the carry-in of segment 0 equals sub.
- REQ-019: Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] of the operands using the carry registered by stage k-1, and registers the partial sum, its carry, and the not-yet-added upper operand segments.
- REQ-020: Pipeline advance condition: adv = !out_valid | out_ready; in_ready = adv (combinational).
- REQ-021: An operation is accepted on a rising edge where in_valid & in_ready; on every edge with adv = 1, all stages shift by one and stage-0 valid loads in_valid.
- REQ-022: When adv = 0 all stage registers hold; sum, flags and out_valid are stable until the edge on which out_ready = 1.
- REQ-023: Latency: an operation accepted on edge N drives out_valid = 1 with its result after edge N+STAGES-1, provided no stall occurs; each stall cycle adds exactly one cycle.
- REQ-024: Throughput: one operation per cycle while out_ready = 1; results leave in acceptance order.
- REQ-025: Bubbles (in_valid = 0 cycles) propagate as invalid slots; they are not compressed during a stall.
- REQ-026: overflow = (a[W-1] == b'[W-1]) & (sum[W-1] != a[W-1]), where b' = in2 or ~in2 per sub.
- REQ-027: carry_out, overflow and zero are registered with sum and belong to the same operation.
- REQ-028: Operands and sub are sampled only on the accept edge; their changes at other times have no effect.
- REQ-029: busy = OR of all stage valid bits, including the output stage.
- REQ-030: Accept and output handshake on the same edge (pipeline full, out_ready = 1, in_valid = 1) completes both; no loss, no duplication.

Reset
- REQ-031: While rst_n = 0: all stage valid bits = 0; out_valid = 0; sum = 0; carry_out = 0; overflow = 0; zero = 0; busy = 0; in_ready = 1.
- REQ-032: Reset asserted mid-operation discards all in-flight operations immediately, without waiting for a clock edge.
- REQ-033: The first accept is possible on the first rising edge after rst_n deasserts.

Verification
- REQ-034: WIDTH=32, STAGES=2, out_ready=1: in1=5, in2=7, sub=0 accepted on edge N -> after edge N+1: out_valid=1, sum=12, carry_out=0, overflow=0, zero=0.
- REQ-035: in1=0xFFFFFFFF, in2=1, sub=0 -> sum=0, carry_out=1, zero=1, overflow=0; the carry crosses the segment boundary.
- REQ-036: in1=0x7FFFFFFF, in2=1, sub=0 -> sum=0x80000000, overflow=1; in1=3, in2=5, sub=1 -> sum=0xFFFFFFFE, carry_out=0, overflow=0.
- REQ-037: Back-to-back stream 1+1, 2+2, 3+3 with out_ready=0 for 3 cycles after the first result -> sum=2 held stable, in_ready=0 during the stall; then results 2, 4, 6 in order, none lost.
- REQ-038: Two operations in flight, rst_n pulsed low between edges -> out_valid=0 and busy=0 immediately; no result emerges after release.
- REQ-039: Repeat REQ-034 to REQ-036 with STAGES=1 (latency 1) and STAGES=4, and with WIDTH=8, STAGES=8; random streams checked against a reference sum model.
